// File: rtl/ram_rsp_buffer.sv
// rtl/ram_rsp_buffer.sv - RAM read-response FWFT buffer with early throttle
// Absorbs the two-cycle ready-to-data pipeline of the RAM read port in a small FIFO.
module ram_rsp_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int SKID       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_rsp_data,
  input  logic [USER_WIDTH-1:0] s_rsp_user,
  input  logic                  s_rsp_valid,
  output logic                  s_rsp_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [USER_WIDTH-1:0] m_user,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  overflow_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int FW    = DEPTH_LOG2 + 2;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [USER_WIDTH-1:0] mem_user [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [CW-1:0]         count;
  logic [FW-1:0]         free_slots;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  assign push    = s_rsp_valid;
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign full    = (count == CW'(DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Ready is raised only when every response already in flight still fits.
  assign free_slots  = FW'(DEPTH) - {1'b0, count};
  assign s_rsp_ready = !rst && (free_slots >= FW'(SKID));

  assign m_data    = m_valid ? mem_data[rd_ptr] : '0;
  assign m_user    = m_valid ? mem_user[rd_ptr] : '0;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_data[wr_ptr] <= s_rsp_data;
      mem_user[wr_ptr] <= s_rsp_user;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_rsp_buffer.sv
// tb/tb_ram_rsp_buffer.sv - directed and RAM-model checks for ram_rsp_buffer
module tb_ram_rsp_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_rsp_data;
  logic [7:0] s_rsp_user;
  logic       s_rsp_valid;
  logic       s_rsp_ready;
  logic [7:0] m_data;
  logic [7:0] m_user;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] occupancy;
  logic       overflow_err;

  int errors = 0;
  int checks = 0;

  ram_rsp_buffer #(.DATA_WIDTH(8), .USER_WIDTH(8), .DEPTH_LOG2(2), .SKID(3)) dut (
    .clk(clk), .rst(rst),
    .s_rsp_data(s_rsp_data), .s_rsp_user(s_rsp_user),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .m_data(m_data), .m_user(m_user), .m_valid(m_valid), .m_ready(m_ready),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    s_rsp_valid = 1'b1;
    s_rsp_data  = d;
    s_rsp_user  = d ^ 8'hFF;
  endtask

  task automatic idle();
    s_rsp_valid = 1'b0;
    s_rsp_data  = 8'h00;
    s_rsp_user  = 8'h00;
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] head;
  logic       r1, r2, rdy_now, req_now;
  int         sent, recv;

  initial begin
    rst = 1'b1; m_ready = 1'b0; idle();
    step(); step();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_ready", 32'(s_rsp_ready), 0);
    check("rst_ovf", 32'(overflow_err), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_user", 32'(m_user), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(s_rsp_ready), 1);

    // Streaming at full rate: each word appears one cycle after arrival
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'h11 + 8'(i));
      step();
      check("t1_valid", 32'(m_valid), 1);
      check("t1_data", 32'(m_data), 32'(8'h11 + 8'(i)));
      check("t1_user", 32'(m_user), 32'((8'h11 + 8'(i)) ^ 8'hFF));
      check("t1_ready", 32'(s_rsp_ready), 1);
      check("t1_occ_le1", 32'(occupancy <= 3'd1), 1);
    end
    idle();
    step();
    check("t1_empty", 32'(m_valid), 0);
    check("t1_ovf", 32'(overflow_err), 0);

    // Stall: throttle drops after the second entry
    m_ready = 1'b0;
    send(8'h21); step();
    check("t2_occ1", 32'(occupancy), 1);
    check("t2_ready1", 32'(s_rsp_ready), 1);
    send(8'h22); step();
    check("t2_occ2", 32'(occupancy), 2);
    check("t2_ready2", 32'(s_rsp_ready), 0);
    check("t2_head2", 32'(m_data), 32'h21);
    send(8'h23); step();
    check("t2_occ3", 32'(occupancy), 3);
    check("t2_ovf", 32'(overflow_err), 0);
    check("t2_head3", 32'(m_data), 32'h21);

    // Full with simultaneous push and pop
    send(8'h24); step();
    check("t4_occ4", 32'(occupancy), 4);
    send(8'h25); m_ready = 1'b1; step();
    check("t4_occ_hold", 32'(occupancy), 4);
    check("t4_head_adv", 32'(m_data), 32'h22);
    check("t4_ovf", 32'(overflow_err), 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", 32'(m_valid), 1);
      check("t4_drain_data", 32'(m_data), 32'(8'h22 + 8'(i)));
      step();
    end
    check("t4_empty", 32'(m_valid), 0);

    // Full with push and no pop: drop and sticky error
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'h31 + 8'(i)); step();
    end
    check("t5_occ4", 32'(occupancy), 4);
    send(8'h99); step();
    check("t5_occ_hold", 32'(occupancy), 4);
    check("t5_ovf_set", 32'(overflow_err), 1);
    idle(); m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_data", 32'(m_data), 32'(8'h31 + 8'(i)));
      step();
    end
    check("t5_empty", 32'(m_valid), 0);
    check("t5_ovf_sticky", 32'(overflow_err), 1);

    // Reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'h41 + 8'(i)); step();
    end
    check("t6_occ3", 32'(occupancy), 3);
    rst = 1'b1; send(8'h55);
    #1;
    check("t6_ready_in_rst", 32'(s_rsp_ready), 0);
    step();
    check("t6_m_valid", 32'(m_valid), 0);
    check("t6_occ0", 32'(occupancy), 0);
    check("t6_ready_rst", 32'(s_rsp_ready), 0);
    check("t6_ovf_clr", 32'(overflow_err), 0);
    rst = 1'b0; idle();
    #1;
    check("t6_ready_after", 32'(s_rsp_ready), 1);
    step();
    check("t6_no_ghost", 32'(m_valid), 0);

    // RAM model: ready registered once, data one cycle later
    r1 = 1'b0; r2 = 1'b0; sent = 0; recv = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rdy_now = s_rsp_ready;
      req_now = rdy_now && ($urandom_range(0, 99) < 80);
      if (r2) begin
        send(8'(sent));
        exp_q.push_back(8'(sent));
        sent++;
      end else begin
        idle();
      end
      m_ready = ($urandom_range(0, 99) < 30);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("t3_unexpected", 32'(m_data), 32'hDEAD);
        end else begin
          head = exp_q.pop_front();
          check("t3_data", 32'(m_data), 32'(head));
          check("t3_user", 32'(m_user), 32'(head ^ 8'hFF));
          recv++;
        end
      end
      step();
      r2 = r1;
      r1 = req_now;
    end
    idle();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) begin
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          check("t3_tail_data", 32'(m_data), 32'(head));
          recv++;
        end
      end
      step();
    end
    check("t3_all_delivered", 32'(recv), 32'(sent));
    check("t3_queue_empty", 32'(exp_q.size()), 0);
    check("t3_ovf", 32'(overflow_err), 0);
    check("t3_final_empty", 32'(m_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
